// File: rtl/fetch_controller_if.sv
// Fetch-stage bundle: instruction memory port, decode-side output handshake, and redirect/halt control.
// master is the fetch controller side, slave is the memory/decode/control environment.
interface fetch_controller_if;
    logic [7:0] inst_addr;
    logic [7:0] instruction;
    logic       out_valid;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic       out_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halt_req;
    logic       resume;
    logic       halted;

    modport master (
        output inst_addr, out_valid, out_instr, out_pc, halted,
        input  instruction, out_ready, redirect, redirect_pc, halt_req, resume
    );

    modport slave (
        input  inst_addr, out_valid, out_instr, out_pc, halted,
        output instruction, out_ready, redirect, redirect_pc, halt_req, resume
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC register feeding a 2-entry prefetch buffer with RUN/HALT control.
// Latency: one edge from PC to buffer head (also after redirect); pops and pushes can overlap for 1 instr/cycle.
// Backpressure: out_ready low stalls pops; fetching stops once both entries are full.
module fetch_controller #(
    parameter logic [7:0] RESET_PC   = 8'h00,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_controller_if.master bus
);
    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t     state;
    logic [7:0] pc;
    logic [1:0] count;
    logic [7:0] e0_instr, e0_pc;
    logic [7:0] e1_instr, e1_pc;
    logic       full, pop, push;

    assign full = (count == DEPTH);
    assign pop  = (count != 2'd0) && bus.out_ready;
    // A full buffer may still accept a fetch when the head leaves on the same edge.
    assign push = (state == RUN) && !bus.halt_req && (!full || pop);

    assign bus.inst_addr = pc;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = e0_instr;
    assign bus.out_pc    = e0_pc;
    assign bus.halted    = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            count    <= 2'd0;
            e0_instr <= 8'h00;
            e0_pc    <= 8'h00;
            e1_instr <= 8'h00;
            e1_pc    <= 8'h00;
        end else if (bus.redirect) begin
            // Redirect wins over everything: flush, retarget, and only a RUN-state halt request changes state.
            count <= 2'd0;
            pc    <= bus.redirect_pc;
            if (state == RUN && bus.halt_req)
                state <= HALT;
        end else begin
            case (state)
                RUN:     if (bus.halt_req) state <= HALT;
                HALT:    if (bus.resume && !bus.halt_req) state <= RUN;
                default: state <= RUN;
            endcase

            if (push)
                pc <= pc + 8'd1;

            case ({push, pop})
                2'b01: begin
                    e0_instr <= e1_instr;
                    e0_pc    <= e1_pc;
                    count    <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        e0_instr <= bus.instruction;
                        e0_pc    <= pc;
                    end else begin
                        e1_instr <= bus.instruction;
                        e1_pc    <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0_instr <= bus.instruction;
                        e0_pc    <= pc;
                    end else begin
                        e0_instr <= e1_instr;
                        e0_pc    <= e1_pc;
                        e1_instr <= bus.instruction;
                        e1_pc    <= pc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: memory model mem[a] = a + 8'h10, expected pcs queued per scenario and
// consumed on every accepted pop; direct checks cover reset, stall, redirect, halt and async reset.
module tb_fetch_controller;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] mem [256];
    logic [7:0] exp_q [$];

    fetch_controller_if bus ();

    fetch_controller #(.RESET_PC(8'h00), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.instruction = mem[bus.inst_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(first + 8'(i));
    endtask

    // Scoreboard: every accepted pop must match the next queued pc and its memory word.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {8'h00, bus.out_pc}, 16'hFFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("pop_pc", {8'h00, bus.out_pc}, {8'h00, e});
                check("pop_instr", {8'h00, bus.out_instr}, {8'h00, e + 8'h10});
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 8'(i) + 8'h10;
        rst_n           = 1'b0;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        bus.halt_req    = 1'b0;
        bus.resume      = 1'b0;

        // Reset state
        tick(2);
        check("rst_valid",  {15'h0, bus.out_valid}, 16'h0);
        check("rst_addr",   {8'h0, bus.inst_addr}, 16'h0);
        check("rst_instr",  {8'h0, bus.out_instr}, 16'h0);
        check("rst_pc",     {8'h0, bus.out_pc}, 16'h0);
        check("rst_halted", {15'h0, bus.halted}, 16'h0);
        rst_n = 1'b1;
        tick();
        check("first_valid", {15'h0, bus.out_valid}, 16'h1);
        check("first_pc",    {8'h0, bus.out_pc}, 16'h0);

        // Streaming: eight instructions in eight cycles
        push_exp(8'h00, 8);
        bus.out_ready = 1'b1;
        tick(8);
        bus.out_ready = 1'b0;
        check("stream_drain", 16'(exp_q.size()), 16'd0);

        // Backpressure after a restart at 0
        exp_q.delete();
        bus.redirect = 1'b1; bus.redirect_pc = 8'h00;
        tick();
        bus.redirect = 1'b0;
        tick(5);
        check("bp_addr",  {8'h0, bus.inst_addr}, 16'h02);
        check("bp_pc",    {8'h0, bus.out_pc}, 16'h00);
        check("bp_valid", {15'h0, bus.out_valid}, 16'h1);
        push_exp(8'h00, 3);
        bus.out_ready = 1'b1;
        tick(3);
        bus.out_ready = 1'b0;
        check("bp_drain", 16'(exp_q.size()), 16'd0);

        // Redirect with a full buffer: stale entries must never be accepted
        tick(2);
        exp_q.delete();
        push_exp(8'h05, 3);
        bus.out_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 8'h05;
        tick();
        bus.redirect = 1'b0;
        check("redir_flush", {15'h0, bus.out_valid}, 16'h0);
        tick();
        check("redir_valid", {15'h0, bus.out_valid}, 16'h1);
        check("redir_pc",    {8'h0, bus.out_pc}, 16'h05);
        check("redir_instr", {8'h0, bus.out_instr}, 16'h15);
        tick(3);
        bus.out_ready = 1'b0;
        check("redir_drain", 16'(exp_q.size()), 16'd0);

        // Halt at PC=3, drain, resume
        exp_q.delete();
        push_exp(8'h00, 3);
        bus.out_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 8'h00;
        tick();
        bus.redirect = 1'b0;
        tick(3);
        check("pre_halt_addr", {8'h0, bus.inst_addr}, 16'h03);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check("halt_halted", {15'h0, bus.halted}, 16'h1);
        check("halt_valid",  {15'h0, bus.out_valid}, 16'h0);
        check("halt_addr",   {8'h0, bus.inst_addr}, 16'h03);
        tick(2);
        check("halt_hold",   {8'h0, bus.inst_addr}, 16'h03);
        check("halt_drain",  16'(exp_q.size()), 16'd0);
        push_exp(8'h03, 2);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("resume_halted", {15'h0, bus.halted}, 16'h0);
        check("resume_valid0", {15'h0, bus.out_valid}, 16'h0);
        tick();
        check("resume_valid1", {15'h0, bus.out_valid}, 16'h1);
        check("resume_pc",     {8'h0, bus.out_pc}, 16'h03);
        tick(2);
        bus.out_ready = 1'b0;
        check("resume_drain", 16'(exp_q.size()), 16'd0);

        // Halt together with redirect, then redirect while halted
        exp_q.delete();
        bus.halt_req = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 8'h80;
        tick();
        bus.halt_req = 1'b0;
        check("hr_halted", {15'h0, bus.halted}, 16'h1);
        check("hr_addr",   {8'h0, bus.inst_addr}, 16'h80);
        check("hr_valid",  {15'h0, bus.out_valid}, 16'h0);
        bus.redirect_pc = 8'hFE;
        tick();
        bus.redirect = 1'b0;
        check("hredir_halted", {15'h0, bus.halted}, 16'h1);
        check("hredir_addr",   {8'h0, bus.inst_addr}, 16'hFE);

        // Wrap FE, FF, 00, 01
        push_exp(8'hFE, 4);
        bus.out_ready = 1'b1;
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        tick();
        check("wrap_first", {8'h0, bus.out_pc}, 16'hFE);
        tick(4);
        bus.out_ready = 1'b0;
        check("wrap_drain", 16'(exp_q.size()), 16'd0);

        // Async reset between edges
        tick(2);
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {15'h0, bus.out_valid}, 16'h0);
        check("arst_addr",  {8'h0, bus.inst_addr}, 16'h00);
        check("arst_pc",    {8'h0, bus.out_pc}, 16'h00);
        tick();
        rst_n = 1'b1;
        push_exp(8'h00, 1);
        tick();
        check("arst_first_valid", {15'h0, bus.out_valid}, 16'h1);
        check("arst_first_pc",    {8'h0, bus.out_pc}, 16'h00);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("arst_drain", 16'(exp_q.size()), 16'd0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
